// File: rtl/compr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : compr_pkg
//  Description : Shared types and helpers for the compressor lead/lag
//                rotation controller (compr_rotator and compr_select).
//                  - state_t      : controller state (IDLE, RUN, BOOST)
//                  - c_max_comp   : largest supported bank size
//                  - next_lead()  : lead pointer advance with wrap
//  Revision    : 1.0 - initial release
// ============================================================================
package compr_pkg;

    localparam int c_max_comp = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BOOST = 2'd2
    } state_t;

    // Advance the lead index by one, wrapping at the bank size n.
    function automatic int next_lead(input int lead, input int n);
        return (lead + 1 >= n) ? 0 : lead + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/compr_select.sv
`default_nettype none
// ============================================================================
//  Module      : compr_select
//  Description : Combinational unit selection for the compressor bank.
//                RUN   : scan from lead with wrap, take the first N_RUN
//                        healthy units; degraded if fewer were found.
//                BOOST : every healthy unit; degraded if any unit faulted.
//                IDLE  : nothing selected, not degraded.
//  Ports       : lead     in  LW      current lead index
//                fault    in  N_COMP  1 = unit unavailable
//                mode     in  state_t state the selection is made for
//                sel      out N_COMP  selected units
//                degraded out 1       fewer units than demanded
//  Revision    : 1.0 - initial release
// ============================================================================
module compr_select
    import compr_pkg::*;
#(
    parameter int N_COMP = 3,
    parameter int N_RUN  = 2,
    parameter int LW     = $clog2(N_COMP)
) (
    input  logic [LW-1:0]     lead,
    input  logic [N_COMP-1:0] fault,
    input  state_t            mode,
    output logic [N_COMP-1:0] sel,
    output logic              degraded
);

    logic [N_COMP-1:0] w_scan_sel;
    logic [N_COMP-1:0] w_bit;
    int                w_scan_cnt;
    int                w_idx;

    // Round-robin scan starting at the lead; a one-hot mask is used so the
    // wrapped index never has to be narrowed to a bit-select width.
    always_comb begin
        w_scan_sel = '0;
        w_scan_cnt = 0;
        w_idx      = 0;
        w_bit      = '0;
        for (int k = 0; k < N_COMP; k++) begin
            w_idx = int'(lead) + k;
            if (w_idx >= N_COMP) begin
                w_idx = w_idx - N_COMP;
            end
            w_bit = {{(N_COMP-1){1'b0}}, 1'b1} << w_idx;
            if (((fault & w_bit) == '0) && (w_scan_cnt < N_RUN)) begin
                w_scan_sel = w_scan_sel | w_bit;
                w_scan_cnt = w_scan_cnt + 1;
            end
        end
    end

    always_comb begin
        sel      = '0;
        degraded = 1'b0;
        case (mode)
            RUN: begin
                sel      = w_scan_sel;
                degraded = (w_scan_cnt < N_RUN);
            end
            BOOST: begin
                sel      = ~fault;
                degraded = |fault;
            end
            default: begin
                sel      = '0;
                degraded = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/compr_rotator.sv
`default_nettype none
// ============================================================================
//  Module      : compr_rotator
//  Description : Lead/lag rotation controller for a bank of N_COMP
//                compressors on one pressure header. Low pressure starts
//                N_RUN units from a rotating lead, very low pressure runs
//                every healthy unit, high pressure stops all and advances
//                the lead. All outputs are registered (1 clock latency).
//  Ports       : Clk      in  1       system clock
//                Reset    in  1       synchronous active-high reset
//                PA       in  1       pressure-high (stop demand)
//                PB       in  1       pressure-low (start demand)
//                PMB      in  1       pressure-very-low (boost demand)
//                Fault    in  N_COMP  1 = unit unavailable
//                C        out N_COMP  compressor run commands
//                Lead     out LW      current lead index
//                Boost    out 1       in BOOST
//                Degraded out 1       fewer units running than demanded
//                SensErr  out 1       PA and PB asserted together
//  Options     : COMPR_ANTI_SHORT_CYCLE_EN - hold off restarts for MIN_OFF
//                clocks after each stop.
//  Revision    : 1.0 - initial release
// ============================================================================
module compr_rotator
    import compr_pkg::*;
#(
    parameter int N_COMP  = 3,
    parameter int N_RUN   = 2,
    parameter int MIN_OFF = 16,
    parameter int LW      = $clog2(N_COMP)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              PA,
    input  logic              PB,
    input  logic              PMB,
    input  logic [N_COMP-1:0] Fault,
    output logic [N_COMP-1:0] C,
    output logic [LW-1:0]     Lead,
    output logic              Boost,
    output logic              Degraded,
    output logic              SensErr
);

    generate
        if ((N_COMP < 2) || (N_COMP > c_max_comp) || (N_RUN < 1) ||
            (N_RUN > N_COMP) || (MIN_OFF < 1)) begin : g_bad_params
            $error("compr_rotator: parameter out of range");
        end
    endgenerate

    state_t            r_state;
    state_t            w_next_state;
    logic              w_advance;
    logic              w_start_ok;
    logic [N_COMP-1:0] w_sel;
    logic              w_degraded;

`ifdef COMPR_ANTI_SHORT_CYCLE_EN
    localparam int               c_tw        = (MIN_OFF > 1) ? $clog2(MIN_OFF) : 1;
    localparam logic [c_tw-1:0]  c_hold_load = c_tw'(MIN_OFF - 1);
    logic [c_tw-1:0]             r_hold;

    assign w_start_ok = (r_hold == '0);
`else
    assign w_start_ok = 1'b1;
`endif

    // PA has priority over PMB, PMB over PB.
    always_comb begin
        w_next_state = r_state;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!PA && PB && w_start_ok) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (PA) begin
                    w_next_state = IDLE;
                    w_advance    = 1'b1;
                end else if (PMB) begin
                    w_next_state = BOOST;
                end
            end
            BOOST: begin
                if (PA) begin
                    w_next_state = IDLE;
                    w_advance    = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Selection is evaluated for the state being entered, so C follows the
    // inputs sampled at this edge and lands one clock later.
    compr_select #(
        .N_COMP (N_COMP),
        .N_RUN  (N_RUN),
        .LW     (LW)
    ) u_select (
        .lead     (Lead),
        .fault    (Fault),
        .mode     (w_next_state),
        .sel      (w_sel),
        .degraded (w_degraded)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            C        <= '0;
            Lead     <= '0;
            Boost    <= 1'b0;
            Degraded <= 1'b0;
            SensErr  <= 1'b0;
`ifdef COMPR_ANTI_SHORT_CYCLE_EN
            r_hold   <= '0;
`endif
        end else begin
            r_state  <= w_next_state;
            C        <= w_sel;
            Boost    <= (w_next_state == BOOST);
            Degraded <= w_degraded;
            SensErr  <= PA & PB;
            if (w_advance) begin
                Lead <= LW'(next_lead(int'(Lead), N_COMP));
            end
`ifdef COMPR_ANTI_SHORT_CYCLE_EN
            if (w_advance) begin
                r_hold <= c_hold_load;
            end else if ((r_state == IDLE) && (r_hold != '0)) begin
                r_hold <= r_hold - 1'b1;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_compr_rotator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_compr_rotator
//  Description : Self-checking bench for compr_rotator: directed sequences
//                with literal expectations, then randomized pressure/fault
//                stimulus compared each cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_compr_rotator;

    localparam int N  = 3;
    localparam int NR = 2;
    localparam int MO = 4;
    localparam int LW = $clog2(N);

    logic          Clk   = 1'b0;
    logic          Reset = 1'b1;
    logic          PA    = 1'b0;
    logic          PB    = 1'b0;
    logic          PMB   = 1'b0;
    logic [N-1:0]  Fault = '0;
    logic [N-1:0]  C;
    logic [LW-1:0] Lead;
    logic          Boost;
    logic          Degraded;
    logic          SensErr;

    always #5 Clk = ~Clk;

    compr_rotator #(
        .N_COMP  (N),
        .N_RUN   (NR),
        .MIN_OFF (MO)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .PA       (PA),
        .PB       (PB),
        .PMB      (PMB),
        .Fault    (Fault),
        .C        (C),
        .Lead     (Lead),
        .Boost    (Boost),
        .Degraded (Degraded),
        .SensErr  (SensErr)
    );

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // m_state: 0 = idle, 1 = running, 2 = boosting
    int           m_state = 0;
    int           m_lead  = 0;
    int           m_timer = 0;
    logic [N-1:0] m_c     = '0;
    bit           m_boost = 1'b0;
    bit           m_deg   = 1'b0;
    bit           m_serr  = 1'b0;
    int           ns, got, idx;
    bit           stop, ok_start;

    always @(posedge Clk) begin
        if (Reset) begin
            m_state = 0; m_lead = 0; m_timer = 0;
            m_c = '0; m_boost = 1'b0; m_deg = 1'b0; m_serr = 1'b0;
        end else begin
            ns = m_state;
            stop = 1'b0;
            ok_start = 1'b1;
`ifdef COMPR_ANTI_SHORT_CYCLE_EN
            ok_start = (m_timer == 0);
`endif
            if (m_state == 0) begin
                if (!PA && PB && ok_start) ns = 1;
            end else if (PA) begin
                ns = 0;
                stop = 1'b1;
            end else if (m_state == 1 && PMB) begin
                ns = 2;
            end
`ifdef COMPR_ANTI_SHORT_CYCLE_EN
            if (stop) m_timer = MO - 1;
            else if (m_state == 0 && m_timer > 0) m_timer = m_timer - 1;
`endif
            m_c = '0;
            m_deg = 1'b0;
            if (ns == 1) begin
                got = 0;
                for (int k = 0; k < N; k++) begin
                    idx = (m_lead + k) % N;
                    if (((Fault >> idx) & 1) == 0 && got < NR) begin
                        m_c = m_c | (N'(1) << idx);
                        got++;
                    end
                end
                m_deg = (got < NR);
            end else if (ns == 2) begin
                m_c = ~Fault;
                m_deg = (Fault != '0);
            end
            m_boost = (ns == 2);
            m_serr = PA && PB;
            if (stop) m_lead = (m_lead + 1) % N;
            m_state = ns;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        if (armed) begin
            check("C",        32'(C),        32'(m_c));
            check("Lead",     32'(Lead),     32'(m_lead));
            check("Boost",    32'(Boost),    32'(m_boost));
            check("Degraded", 32'(Degraded), 32'(m_deg));
            check("SensErr",  32'(SensErr),  32'(m_serr));
        end
    end

    task automatic drive(input logic pa, input logic pb, input logic pmb,
                         input logic [N-1:0] f, input logic r);
        @(negedge Clk);
        Reset = r; PA = pa; PB = pb; PMB = pmb; Fault = f;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    logic         r_r, r_pa, r_pb, r_pmb;
    logic [N-1:0] r_f;

    initial begin
        drive(0, 0, 0, '0, 1);
        drive(0, 0, 0, '0, 1);
        armed = 1'b1;
        check("rst_C",    32'(C), 0);
        check("rst_Lead", 32'(Lead), 0);
        check("rst_Boost", 32'(Boost), 0);
        check("rst_Deg",  32'(Degraded), 0);
        check("rst_SE",   32'(SensErr), 0);

        drive(0, 1, 0, '0, 0);
        check("start0_C", 32'(C), 32'h3);
        check("start0_Lead", 32'(Lead), 0);
        drive(1, 0, 0, '0, 0);
        check("stop0_C", 32'(C), 0);
        check("stop0_Lead", 32'(Lead), 1);
        idle(4);
        drive(0, 1, 0, '0, 0);
        check("start1_C", 32'(C), 32'h6);
        drive(1, 1, 0, '0, 0);
        check("stop1_C", 32'(C), 0);
        check("stop1_Lead", 32'(Lead), 2);
        check("stop1_SE", 32'(SensErr), 1);
        idle(4);
        drive(0, 1, 0, '0, 0);
        check("start2_C", 32'(C), 32'h5);
        drive(0, 1, 1, '0, 0);
        check("boost_C", 32'(C), 32'h7);
        check("boost_B", 32'(Boost), 1);
        drive(1, 0, 0, '0, 0);
        check("bstop_C", 32'(C), 0);
        check("bstop_B", 32'(Boost), 0);
        check("bstop_Lead", 32'(Lead), 0);

        idle(4);
        drive(0, 1, 0, 3'b010, 0);
        check("flt1_C", 32'(C), 32'h5);
        check("flt1_Deg", 32'(Degraded), 0);
        drive(0, 1, 0, 3'b011, 0);
        check("flt2_C", 32'(C), 32'h4);
        check("flt2_Deg", 32'(Degraded), 1);
        drive(1, 0, 0, '0, 0);
        check("flt_stop_Lead", 32'(Lead), 1);

        idle(4);
        drive(1, 1, 0, '0, 0);
        check("se_idle_SE", 32'(SensErr), 1);
        check("se_idle_C", 32'(C), 0);
        drive(0, 0, 1, '0, 0);
        check("se_after_C", 32'(C), 0);
        check("se_after_SE", 32'(SensErr), 0);
        check("se_after_B", 32'(Boost), 0);

        drive(0, 1, 0, '0, 0);
        check("pre_rst_C", 32'(C), 32'h6);
        drive(0, 0, 1, '0, 0);
        check("pre_rst_boost", 32'(C), 32'h7);
        drive(0, 1, 1, '0, 1);
        check("midrst_C", 32'(C), 0);
        check("midrst_Lead", 32'(Lead), 0);
        check("midrst_B", 32'(Boost), 0);

        drive(0, 1, 0, 3'b111, 0);
        check("allflt_C", 32'(C), 0);
        check("allflt_Deg", 32'(Degraded), 1);
        drive(0, 0, 1, 3'b111, 0);
        check("allflt_B", 32'(Boost), 1);
        check("allflt_bC", 32'(C), 0);
        drive(1, 0, 0, 3'b111, 0);
        check("allflt_Lead", 32'(Lead), 1);
        check("allflt_stopDeg", 32'(Degraded), 0);

`ifdef COMPR_ANTI_SHORT_CYCLE_EN
        repeat (3) begin
            drive(0, 1, 0, '0, 0);
            check("hold_C", 32'(C), 0);
        end
        drive(0, 1, 0, '0, 0);
        check("hold_rel_C", 32'(C), 32'h6);
`else
        drive(0, 1, 0, '0, 0);
        check("restart_C", 32'(C), 32'h6);
`endif

        for (int i = 0; i < 3000; i++) begin
            r_r   = ($urandom_range(63) == 0);
            r_pa  = ($urandom_range(7) == 0);
            r_pb  = ($urandom_range(2) == 0);
            r_pmb = ($urandom_range(5) == 0);
            r_f   = ($urandom_range(3) == 0) ? N'($urandom) : '0;
            drive(r_pa, r_pb, r_pmb, r_f, r_r);
        end

        @(negedge Clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
